// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game controller: state encoding, score format
// and a BCD increment helper used by the score counter.
package flappy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_PLAYING = 3'd2,
    ST_DYING   = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned SCORE_DIGITS = 3;
  localparam int unsigned SCORE_W      = DIGIT_W * SCORE_DIGITS;
  localparam logic [SCORE_W-1:0] MAX_SCORE = 12'h999;

  // Ripple a +1 through the BCD digits, ones first.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic               carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (r[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
          r[i*DIGIT_W +: DIGIT_W] = 4'd0;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = r[i*DIGIT_W +: DIGIT_W] + 4'd1;
          carry                   = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_bcd_counter3.sv
// Three-digit BCD counter with synchronous clear and increment, saturating at 999.
module bcd_counter3
  import flappy_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] bcd
);

  logic [SCORE_W-1:0] r_bcd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd <= '0;
    end else if (clr) begin
      r_bcd <= '0;
    end else if (inc && (r_bcd != MAX_SCORE)) begin
      r_bcd <= bcd_inc(r_bcd);
    end
  end

  assign bcd = r_bcd;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game-flow controller: IDLE->START->PLAYING->DYING->OVER sequencing, button sync,
// BCD score. High-score tracking is built only when FLAPPY_HISCORE_EN is defined.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned DEATH_FRAMES   = 30,
  parameter int unsigned LOCKOUT_FRAMES = 45,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        flap_btn,
  input  logic        pipe_collision,
  input  logic        pipe_passed,
  input  logic        ground_hit,
  output logic        game_enable,
  output logic        world_rst,
  output logic        flap_pulse,
  output logic [2:0]  game_state,
  output logic [11:0] score_bcd,
  output logic [11:0] hiscore_bcd,
  output logic        new_hiscore
);

  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] LOCK_END   = 8'(LOCKOUT_FRAMES);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_btn_prev;
  logic                   r_btn_edge;
  logic [7:0]             r_frame_cnt;
  logic                   r_game_en;
  logic                   r_wrst;
  logic                   r_flap;
  logic                   w_hit;
  logic                   w_inc;
  logic                   w_clr;
  logic [SCORE_W-1:0]     w_score;

  assign w_hit = pipe_collision | ground_hit;
  // A hit in the same clock as a pass wins; the pass is dropped.
  assign w_inc = (r_state == ST_PLAYING) & pipe_passed & ~w_hit;
  assign w_clr = (r_state == ST_START);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync     <= '0;
      r_btn_prev <= 1'b0;
      r_btn_edge <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], flap_btn};
      r_btn_prev <= r_sync[SYNC_STAGES-1];
      r_btn_edge <= r_sync[SYNC_STAGES-1] & ~r_btn_prev;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
      r_game_en   <= 1'b0;
      r_wrst      <= 1'b0;
      r_flap      <= 1'b0;
    end else begin
      r_wrst <= 1'b0;
      r_flap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_game_en <= 1'b0;
          if (r_btn_edge) begin
            r_state <= ST_START;
            r_flap  <= 1'b1;
            r_wrst  <= 1'b1;
          end
        end
        ST_START: begin
          r_state   <= ST_PLAYING;
          r_game_en <= 1'b1;
        end
        ST_PLAYING: begin
          if (w_hit) begin
            r_state     <= ST_DYING;
            r_game_en   <= 1'b0;
            r_frame_cnt <= '0;
          end else if (r_btn_edge) begin
            r_flap <= 1'b1;
          end
        end
        ST_DYING: begin
          r_game_en <= 1'b0;
          if (frame_tick) begin
            if (r_frame_cnt == DEATH_LAST) begin
              r_state     <= ST_OVER;
              r_frame_cnt <= '0;
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        ST_OVER: begin
          r_game_en <= 1'b0;
          if (r_btn_edge && (r_frame_cnt == LOCK_END)) begin
            r_state <= ST_START;
            r_flap  <= 1'b1;
            r_wrst  <= 1'b1;
          end else if (frame_tick && (r_frame_cnt != LOCK_END)) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_game_en <= 1'b0;
        end
      endcase
    end
  end

  bcd_counter3 u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .inc     (w_inc),
    .bcd     (w_score)
  );

`ifdef FLAPPY_HISCORE_EN
  logic [SCORE_W-1:0] r_hiscore;
  logic               r_new_hi;

  // Packed BCD compares correctly as an unsigned number.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hiscore <= '0;
      r_new_hi  <= 1'b0;
    end else begin
      if (r_state == ST_START) begin
        r_new_hi <= 1'b0;
      end else if ((r_state == ST_PLAYING) && (w_score > r_hiscore)) begin
        r_new_hi <= 1'b1;
      end
      if ((r_state == ST_PLAYING) && w_hit && (w_score > r_hiscore)) begin
        r_hiscore <= w_score;
      end
    end
  end

  assign hiscore_bcd = r_hiscore;
  assign new_hiscore = r_new_hi;
`else
  assign hiscore_bcd = '0;
  assign new_hiscore = 1'b0;
`endif

  assign game_enable = r_game_en;
  assign world_rst   = r_wrst;
  assign flap_pulse  = r_flap;
  assign game_state  = r_state;
  assign score_bcd   = w_score;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed self-checking bench for flappy_game_ctrl (hiscore checks follow FLAPPY_HISCORE_EN).
module tb_flappy_game_ctrl;

`ifdef FLAPPY_HISCORE_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick, flap_btn, pipe_collision, pipe_passed, ground_hit;
  logic        game_enable, world_rst, flap_pulse, new_hiscore;
  logic [2:0]  game_state;
  logic [11:0] score_bcd, hiscore_bcd;

  int checks   = 0;
  int failures = 0;
  int nf, nw;

  always #5 clk = ~clk;

  flappy_game_ctrl #(
    .DEATH_FRAMES   (30),
    .LOCKOUT_FRAMES (45),
    .SYNC_STAGES    (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .flap_btn       (flap_btn),
    .pipe_collision (pipe_collision),
    .pipe_passed    (pipe_passed),
    .ground_hit     (ground_hit),
    .game_enable    (game_enable),
    .world_rst      (world_rst),
    .flap_pulse     (flap_pulse),
    .game_state     (game_state),
    .score_bcd      (score_bcd),
    .hiscore_bcd    (hiscore_bcd),
    .new_hiscore    (new_hiscore)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pass();
    pipe_passed = 1'b1; step();
    pipe_passed = 1'b0; step();
  endtask

  task automatic tick();
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();
  endtask

  task automatic die_restart();
    ground_hit = 1'b1; step();
    ground_hit = 1'b0;
    repeat (30) tick();
    repeat (45) tick();
    flap_btn = 1'b1; repeat (5) step();
    flap_btn = 1'b0; repeat (3) step();
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; flap_btn = 1'b0;
    pipe_collision = 1'b0; pipe_passed = 1'b0; ground_hit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 12'(game_state), 12'd0);
    chk("rst_score", score_bcd, 12'h000);
    chk("rst_outs", 12'({game_enable, world_rst, flap_pulse, new_hiscore}), 12'd0);
    reset_n = 1'b1;
    step();
    chk("idle_state", 12'(game_state), 12'd0);

    // Start: one flap and one world reset, PLAYING five clocks after the press
    flap_btn = 1'b1; nf = 0; nw = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      nf += int'(flap_pulse);
      nw += int'(world_rst);
      if (i == 4) begin
        chk("start_state", 12'(game_state), 12'd1);
        chk("start_flap", 12'(flap_pulse), 12'd1);
        chk("start_wrst", 12'(world_rst), 12'd1);
      end
      if (i == 5) begin
        chk("play_state", 12'(game_state), 12'd2);
        chk("play_enable", 12'(game_enable), 12'd1);
        flap_btn = 1'b0;
      end
    end
    chk("start_flap_cnt", 12'(nf), 12'd1);
    chk("start_wrst_cnt", 12'(nw), 12'd1);

    // Run A: 7 points, then pass+collision+flap together
    repeat (7) pass();
    chk("runA_score", score_bcd, 12'h007);
    chk("runA_newhi", 12'(new_hiscore), 12'(HI));
    flap_btn = 1'b1;
    repeat (3) step();
    pipe_passed = 1'b1; pipe_collision = 1'b1;
    step();
    pipe_passed = 1'b0; pipe_collision = 1'b0;
    chk("hit_state", 12'(game_state), 12'd3);
    chk("hit_flap_sup", 12'(flap_pulse), 12'd0);
    chk("hit_score", score_bcd, 12'h007);
    chk("hit_enable", 12'(game_enable), 12'd0);
    flap_btn = 1'b0;
    step();
    chk("runA_hiscore", hiscore_bcd, HI ? 12'h007 : 12'h000);
    pass();
    chk("dying_pass_ign", score_bcd, 12'h007);

    // Death timer and lockout
    repeat (29) tick();
    chk("dying_29", 12'(game_state), 12'd3);
    tick();
    chk("over_30", 12'(game_state), 12'd4);
    repeat (10) tick();
    flap_btn = 1'b1; nf = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      nf += int'(flap_pulse);
    end
    chk("lock_flap_cnt", 12'(nf), 12'd0);
    chk("lock_state", 12'(game_state), 12'd4);
    flap_btn = 1'b0; repeat (4) step();
    repeat (35) tick();
    chk("over_45", 12'(game_state), 12'd4);
    flap_btn = 1'b1; repeat (4) step();
    chk("restart_state", 12'(game_state), 12'd1);
    chk("restart_flap", 12'(flap_pulse), 12'd1);
    chk("restart_wrst", 12'(world_rst), 12'd1);
    step();
    chk("runB_state", 12'(game_state), 12'd2);
    chk("runB_score0", score_bcd, 12'h000);
    chk("runB_newhi0", 12'(new_hiscore), 12'd0);
    flap_btn = 1'b0; repeat (3) step();

    // Run B: beats 7 on the 8th pass, ends at 9
    repeat (7) pass();
    chk("runB_newhi7", 12'(new_hiscore), 12'd0);
    pass();
    chk("runB_newhi8", 12'(new_hiscore), 12'(HI));
    pass();
    chk("runB_score", score_bcd, 12'h009);
    ground_hit = 1'b1; step(); ground_hit = 1'b0;
    chk("ground_state", 12'(game_state), 12'd3);
    step();
    chk("runB_hiscore", hiscore_bcd, HI ? 12'h009 : 12'h000);
    repeat (30) tick();
    repeat (45) tick();
    flap_btn = 1'b1; repeat (5) step();
    flap_btn = 1'b0; repeat (3) step();

    // Run C: flap in play, then score carry and saturation
    flap_btn = 1'b1; repeat (4) step();
    chk("play_flap", 12'(flap_pulse), 12'd1);
    step();
    chk("play_flap_1clk", 12'(flap_pulse), 12'd0);
    flap_btn = 1'b0; repeat (3) step();
    repeat (12) pass();
    chk("score_012", score_bcd, 12'h012);
    repeat (987) pass();
    chk("score_999", score_bcd, 12'h999);
    repeat (6) pass();
    chk("score_sat", score_bcd, 12'h999);

    // Run D: asynchronous reset mid-game
    die_restart();
    repeat (5) pass();
    chk("runD_score", score_bcd, 12'h005);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_state", 12'(game_state), 12'd0);
    chk("async_score", score_bcd, 12'h000);
    chk("async_hiscore", hiscore_bcd, 12'h000);
    chk("async_outs", 12'({game_enable, world_rst, flap_pulse, new_hiscore}), 12'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
